arb_requester: RTL and testbench

- Requester-side agent for the 2-bit request/grant arbiter.
- Takes transfer jobs from NUM_REQ local clients and raises the matching request bit.
- Waits for the matching grant bit, holds ownership for a programmed number of beats, then releases.
- Reports completion, grant timeouts and lost-grant protocol errors. Sits between client logic and the arbiter, driving request and sampling grant.

---
 rtl/arb_req_pkg.sv | 16 +
 rtl/arb_req_chan.sv | 114 +++++++++++
 rtl/arb_requester.sv | 46 ++++
 tb/tb_arb_requester.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_req_pkg.sv
// Shared types and default sizing for the arbiter requester agent.
// The channel FSM state encoding is shared so every channel decodes it the same way.
package arb_req_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int LEN_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } chan_state_e;

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: takes a job, requests the bus, owns it for len+1 beats, then releases.
//   state | meaning
//   IDLE  | ready for a job, request low
//   REQ   | request high, waiting for grant (bounded by TIMEOUT)
//   OWN   | bus owned, counting beats down to zero
//   REL   | one-cycle release gap, stale grants ignored
module arb_req_chan
  import arb_req_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  input  logic             grant,
  output logic             job_ready,
  output logic             request,
  output logic             xfer_active,
  output logic             done,
  output logic             timeout_err,
  output logic             proto_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

  chan_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             proto_q, proto_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      to_q    <= to_d;
      proto_q <= proto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    proto_d = proto_q;
    case (state_q)
      IDLE: begin
        if (job_valid) begin
          len_d   = job_len;
          wait_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // grant outranks a timeout landing in the same cycle
        if (grant) begin
          beat_d  = len_q;
          state_d = OWN;
        end else if (wait_q == WAIT_LAST) begin
          to_d    = 1'b1;
          state_d = REL;
        end
        if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      OWN: begin
        if (!grant) begin
          proto_d = 1'b1;
          state_d = REL;
        end else if (beat_q == '0) begin
          done_d  = 1'b1;
          state_d = REL;
        end else begin
          beat_d = beat_q - 1'b1;
        end
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign job_ready   = (state_q == IDLE);
  assign request     = (state_q == REQ) || (state_q == OWN);
  assign xfer_active = (state_q == OWN);
  assign done        = done_q;
  assign timeout_err = to_q;
  assign proto_err   = proto_q;

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for the request/grant arbiter: NUM_REQ independent channels.
// Per-channel protocol error flags are already sticky, so the top flag is their OR.
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       job_valid,
  input  logic [NUM_REQ*LEN_W-1:0] job_len,
  output logic [NUM_REQ-1:0]       job_ready,
  output logic [NUM_REQ-1:0]       request,
  input  logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       xfer_active,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       timeout_err,
  output logic                     proto_err
);

  logic [NUM_REQ-1:0] chan_proto;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
    arb_req_chan #(
      .LEN_W  (LEN_W),
      .TIMEOUT(TIMEOUT)
    ) u_chan (
      .clk        (clk),
      .rst_n      (reset),
      .job_valid  (job_valid[i]),
      .job_len    (job_len[i*LEN_W +: LEN_W]),
      .grant      (grant[i]),
      .job_ready  (job_ready[i]),
      .request    (request[i]),
      .xfer_active(xfer_active[i]),
      .done       (done[i]),
      .timeout_err(timeout_err[i]),
      .proto_err  (chan_proto[i])
    );
  end

  assign proto_err = |chan_proto;

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: a lagging-grant arbiter model drives grant,
// and per-job request/ownership/pulse counts are predicted from lag, len and TIMEOUT.
module tb_arb_requester;

  localparam int NR = 2;
  localparam int LW = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NR-1:0]  job_valid = '0;
  logic [NR*LW-1:0] job_len = '0;
  logic [NR-1:0]  grant = '0;
  logic [NR-1:0]  job_ready, request, xfer_active, done, timeout_err;
  logic           proto_err;

  always #5 clk = ~clk;

  arb_requester #(.NUM_REQ(NR), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_len    (job_len),
    .job_ready  (job_ready),
    .request    (request),
    .grant      (grant),
    .xfer_active(xfer_active),
    .done       (done),
    .timeout_err(timeout_err),
    .proto_err  (proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // observed per-channel cycle counts: request, xfer_active, done, timeout_err, release gap
  int obs[NR][5];
  int ex[NR][5];
  string mn[5] = '{"request", "xfer_active", "done", "timeout_err", "rel_gap"};
  int bad_done;
  logic [31:0] hist[NR];
  int lag[NR];
  bit auto_g[NR];
  bit gforce[NR];
  int drop_at[NR];
  logic [NR-1:0] prev_xa;

  task automatic clear_stats();
    for (int c = 0; c < NR; c++) begin
      for (int m = 0; m < 5; m++) obs[c][m] = 0;
      hist[c] = '0;
    end
    prev_xa  = '0;
    bad_done = 0;
  endtask

  task automatic setup(input bit a0, input int l0, input bit a1, input int l1);
    auto_g[0] = a0; lag[0] = l0; gforce[0] = 1'b0; drop_at[0] = -1;
    auto_g[1] = a1; lag[1] = l1; gforce[1] = 1'b0; drop_at[1] = -1;
  endtask

  // Advance one clock, sample outputs, then drive the arbiter's grant for the next edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int c = 0; c < NR; c++) begin
      if (request[c])     obs[c][0]++;
      if (xfer_active[c]) obs[c][1]++;
      if (done[c])        obs[c][2]++;
      if (timeout_err[c]) obs[c][3]++;
      if (!request[c] && !job_ready[c]) obs[c][4]++;
      if (done[c] && !(prev_xa[c] && !xfer_active[c])) bad_done++;
      prev_xa[c] = xfer_active[c];
      hist[c] = {hist[c][30:0], request[c]};
      grant[c] = auto_g[c] ? hist[c][lag[c]] : gforce[c];
      if (drop_at[c] >= 0 && xfer_active[c] && obs[c][1] == drop_at[c]) grant[c] = 1'b0;
    end
  endtask

  task automatic offer(input logic [NR-1:0] which, input logic [LW-1:0] l0, input logic [LW-1:0] l1);
    for (int c = 0; c < NR; c++) begin
      hist[c] = '0;
      if (auto_g[c]) grant[c] = 1'b0;
    end
    job_len   = {l1, l0};
    job_valid = which;
    cycle();
    job_valid = '0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (job_ready == {NR{1'b1}}) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      grant = NR'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      n_checks++;
      if ({request, xfer_active, done, timeout_err, proto_err, job_ready} !== {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11})
        $display("FAIL reset cyc%0d: got req=%b xa=%b done=%b to=%b perr=%b rdy=%b want 00 00 00 00 0 11",
                 k, request, xfer_active, done, timeout_err, proto_err, job_ready);
      else n_pass++;
    end
    grant = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    setup(1, 2, 0, 1);
    clear_stats();
    n_checks++;
    if (job_ready !== 2'b11) $display("FAIL single_ready_before: got %b want 11", job_ready);
    else n_pass++;
    offer(2'b01, 4'd3, 4'd0);
    n_checks++;
    if (request !== 2'b01) $display("FAIL single_req_rise: got %b want 01", request);
    else n_pass++;
    wait_idle(ok);
    n_checks++;
    if (!ok) $display("FAIL single_idle: got busy want idle");
    else n_pass++;
    ex = '{'{7, 4, 1, 0, 1}, '{0, 0, 0, 0, 0}};
    for (int c = 0; c < NR; c++)
      for (int m = 0; m < 5; m++) begin
        n_checks++;
        if (obs[c][m] !== ex[c][m])
          $display("FAIL single ch%0d %s cycles: got %0d want %0d", c, mn[m], obs[c][m], ex[c][m]);
        else n_pass++;
      end
    n_checks++;
    if (bad_done !== 0) $display("FAIL single_done_timing: got %0d misplaced want 0", bad_done);
    else n_pass++;
  endtask

  task automatic test_dual();
    bit ok;
    setup(1, 2, 1, 2);
    clear_stats();
    offer(2'b11, 4'd0, 4'd2);
    wait_idle(ok);
    n_checks++;
    if (!ok) $display("FAIL dual_idle: got busy want idle");
    else n_pass++;
    ex = '{'{4, 1, 1, 0, 1}, '{6, 3, 1, 0, 1}};
    for (int c = 0; c < NR; c++)
      for (int m = 0; m < 5; m++) begin
        n_checks++;
        if (obs[c][m] !== ex[c][m])
          $display("FAIL dual ch%0d %s cycles: got %0d want %0d", c, mn[m], obs[c][m], ex[c][m]);
        else n_pass++;
      end
    n_checks++;
    if (proto_err !== 1'b0 || bad_done !== 0)
      $display("FAIL dual_clean: got perr=%b bad_done=%0d want 0 0", proto_err, bad_done);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    setup(0, 1, 0, 1);
    clear_stats();
    offer(2'b10, 4'd0, 4'd5);
    wait_idle(ok);
    n_checks++;
    if (!ok) $display("FAIL timeout_idle: got busy want idle");
    else n_pass++;
    ex = '{'{0, 0, 0, 0, 0}, '{TO, 0, 0, 1, 1}};
    for (int c = 0; c < NR; c++)
      for (int m = 0; m < 5; m++) begin
        n_checks++;
        if (obs[c][m] !== ex[c][m])
          $display("FAIL timeout ch%0d %s cycles: got %0d want %0d", c, mn[m], obs[c][m], ex[c][m]);
        else n_pass++;
      end
  endtask

  // Random lags and lengths; lag below TIMEOUT means granted, otherwise a timeout.
  task automatic test_random();
    bit ok;
    logic [NR-1:0] which;
    int ln[NR];
    int lg[NR];
    for (int it = 0; it < 24; it++) begin
      which = NR'($urandom_range(1, 3));
      for (int c = 0; c < NR; c++) begin
        ln[c] = $urandom_range(0, (1 << LW) - 1);
        lg[c] = (it == 0) ? TO - 1 : (it == 1) ? TO : $urandom_range(1, 20);
      end
      setup(1, lg[0], 1, lg[1]);
      clear_stats();
      n_checks++;
      if (job_ready !== 2'b11) $display("FAIL rand%0d_ready: got %b want 11", it, job_ready);
      else n_pass++;
      offer(which, LW'(ln[0]), LW'(ln[1]));
      wait_idle(ok);
      n_checks++;
      if (!ok) $display("FAIL rand%0d_idle: got busy want idle", it);
      else n_pass++;
      for (int c = 0; c < NR; c++) begin
        if (!which[c]) ex[c] = '{0, 0, 0, 0, 0};
        else if (lg[c] < TO) ex[c] = '{lg[c] + 1 + ln[c] + 1, ln[c] + 1, 1, 0, 1};
        else ex[c] = '{TO, 0, 0, 1, 1};
        for (int m = 0; m < 5; m++) begin
          n_checks++;
          if (obs[c][m] !== ex[c][m])
            $display("FAIL rand%0d ch%0d %s cycles (lag %0d len %0d): got %0d want %0d",
                     it, c, mn[m], lg[c], ln[c], obs[c][m], ex[c][m]);
          else n_pass++;
        end
      end
      n_checks++;
      if (bad_done !== 0) $display("FAIL rand%0d_done_timing: got %0d misplaced want 0", it, bad_done);
      else n_pass++;
    end
    n_checks++;
    if (proto_err !== 1'b0) $display("FAIL rand_proto: got %b want 0", proto_err);
    else n_pass++;
  endtask

  task automatic test_lost_grant();
    bit ok;
    int ln;
    setup(1, 2, 0, 1);
    drop_at[0] = 3;
    clear_stats();
    offer(2'b01, 4'd7, 4'd0);
    for (int k = 0; k < 50; k++) begin
      if (obs[0][1] == 3) break;
      cycle();
    end
    n_checks++;
    if (obs[0][1] !== 3) $display("FAIL lost_reach_own3: got %0d own cycles want 3", obs[0][1]);
    else n_pass++;
    cycle();
    n_checks++;
    if ({proto_err, request[0], xfer_active[0]} !== 3'b100)
      $display("FAIL lost_next: got perr=%b req0=%b xa0=%b want 1 0 0", proto_err, request[0], xfer_active[0]);
    else n_pass++;
    wait_idle(ok);
    n_checks++;
    if (!ok || obs[0][2] !== 0 || obs[0][1] !== 3)
      $display("FAIL lost_summary: got idle=%0d done=%0d own=%0d want 1 0 3", ok, obs[0][2], obs[0][1]);
    else n_pass++;
    drop_at[0] = -1;
    ln = $urandom_range(0, 15);
    clear_stats();
    offer(2'b01, LW'(ln), 4'd0);
    wait_idle(ok);
    n_checks++;
    if (!ok || obs[0][2] !== 1 || obs[0][1] !== ln + 1)
      $display("FAIL lost_clean_job: got idle=%0d done=%0d own=%0d want 1 1 %0d", ok, obs[0][2], obs[0][1], ln + 1);
    else n_pass++;
    n_checks++;
    if (proto_err !== 1'b1) $display("FAIL lost_sticky: got %b want 1", proto_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_own();
    bit ok;
    setup(1, 2, 0, 1);
    clear_stats();
    offer(2'b01, 4'd15, 4'd0);
    for (int k = 0; k < 50; k++) begin
      if (obs[0][1] == 5) break;
      cycle();
    end
    n_checks++;
    if (obs[0][1] !== 5) $display("FAIL midrst_reach: got %0d own cycles want 5", obs[0][1]);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({request, xfer_active, done, timeout_err, proto_err, job_ready} !== {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11})
      $display("FAIL midrst_async: got req=%b xa=%b done=%b to=%b perr=%b rdy=%b want 00 00 00 00 0 11",
               request, xfer_active, done, timeout_err, proto_err, job_ready);
    else n_pass++;
    grant = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_stats();
    offer(2'b01, 4'd1, 4'd0);
    wait_idle(ok);
    n_checks++;
    if (!ok) $display("FAIL midrst_idle: got busy want idle");
    else n_pass++;
    ex = '{'{5, 2, 1, 0, 1}, '{0, 0, 0, 0, 0}};
    for (int c = 0; c < NR; c++)
      for (int m = 0; m < 5; m++) begin
        n_checks++;
        if (obs[c][m] !== ex[c][m])
          $display("FAIL midrst ch%0d %s cycles: got %0d want %0d", c, mn[m], obs[c][m], ex[c][m]);
        else n_pass++;
      end
    n_checks++;
    if (proto_err !== 1'b0 || bad_done !== 0)
      $display("FAIL midrst_clean: got perr=%b bad_done=%0d want 0 0", proto_err, bad_done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_timeout();
    test_random();
    test_lost_grant();
    test_reset_mid_own();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
